uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_tx_ctrl.sv | 125 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and default sizing for the transmit controller.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud divider: counts clk cycles within one serial bit and pulses tick on the last one.
// The count also restarts by itself after each tick, so consecutive bits in one state stay aligned.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic arst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] count;

    assign tick = (count == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            count <= '0;
        else if (clear || tick)
            count <= '0;
        else
            count <= count + CW'(1);
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller driving an external parallel-load shift cell.
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    input  logic                  sr_lsb,
    output logic                  parallel_load_en,
    output logic                  shifting_enable,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_tx_state_t state, state_nxt;
    logic [BW-1:0]  bit_cnt, bit_cnt_nxt;
    logic           tick;
    logic           tx_nxt;
    logic           last_bit;

    // Payload travels straight to the shift cell; the controller only sees its LSB.
    logic unused_data;
    assign unused_data = ^tx_data;

`ifdef UART_TX_PARITY_EN
    logic par, par_nxt;
`endif

    assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = (state != ST_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .arst (arst),
        .clear((state_nxt != state) || (state == ST_IDLE)),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx      <= tx_nxt;
`ifdef UART_TX_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

    // tx is the registered image of the per-state line level, so the line
    // trails the state by one cycle while every bit still spans CLKS_PER_BIT.
    always_comb begin
        state_nxt        = state;
        bit_cnt_nxt      = bit_cnt;
        parallel_load_en = 1'b0;
        shifting_enable  = 1'b0;
        tx_nxt           = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_nxt          = par;
`endif
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    parallel_load_en = 1'b1;
                    state_nxt        = ST_START;
                end
            end
            ST_START: begin
                tx_nxt = 1'b0;
                if (tick) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                tx_nxt = sr_lsb;
                if (tick) begin
                    shifting_enable = 1'b1;
                    bit_cnt_nxt     = bit_cnt + BW'(1);
`ifdef UART_TX_PARITY_EN
                    par_nxt         = par ^ sr_lsb;
                    if (last_bit) state_nxt = ST_PARITY;
`else
                    if (last_bit) state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_nxt = par;
                if (tick) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                tx_nxt = 1'b1;
                if (tick) begin
                    state_nxt = ST_IDLE;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = 1'b0;
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural shift cell; frame length
// follows UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = DW + 3;
`else
    localparam int FB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready, sr_lsb, ple, se, tx, tx_busy;
    logic [DW-1:0] sr = '0;

    int se_total = 0;
    int overlap  = 0;
    int total = 0, passed = 0, fails = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .arst            (arst),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .sr_lsb          (sr_lsb),
        .parallel_load_en(ple),
        .shifting_enable (se),
        .tx              (tx),
        .tx_busy         (tx_busy)
    );

    // External shift cell: parallel load, shift right toward the LSB.
    always @(posedge clk) begin
        if (ple)     sr <= tx_data;
        else if (se) sr <= sr >> 1;
    end
    assign sr_lsb = sr[0];

    always @(posedge clk) begin
        if (se)        se_total <= se_total + 1;
        if (ple && se) overlap  <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the controller idle; returns at the negedge
    // holding the last stop-bit sample, when the controller is idle again.
    task automatic send_frame(input logic [DW-1:0] d, input bit hold);
        logic [FB-1:0] bits;
        int se0;
        bits = '1;
        bits[0] = 1'b0;
        bits[DW:1] = d;
`ifdef UART_TX_PARITY_EN
        bits[DW+1] = ^d;
`endif
        tx_valid = 1'b1;
        tx_data  = d;
        #1;
        chk("load", 32'(ple), 1);
        chk("ready", 32'(tx_ready), 1);
        chk("idle_tx", 32'(tx), 1);
        se0 = se_total;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        tx_data = d ^ {DW{1'b1}};
        #1;
        chk("busy", 32'(tx_busy), 1);
        chk("one_load", 32'(ple), 0);
        for (int b = 0; b < FB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                chk($sformatf("d%02h_bit%0d", d, b), 32'(tx), 32'(bits[b]));
            end
        end
        chk("ready_end", 32'(tx_ready), 1);
        chk("shifts", 32'(se_total - se0), DW);
    endtask

    initial begin
        bit hold;
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_load", 32'(ple), 0);
        chk("rst_shift", 32'(se), 0);
        arst = 1'b0;
        @(negedge clk);

        send_frame(8'hA5, 1'b0);
        @(negedge clk);
        send_frame(8'h01, 1'b0);
        @(negedge clk);

        // Back-to-back with tx_valid held; data flips mid-frame.
        send_frame(8'h0F, 1'b1);
        send_frame(8'hF0, 1'b0);
        @(negedge clk);

        // Abort during data bit 3.
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_abort_busy", 32'(tx_busy), 1);
        arst = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 1);
        chk("abort_ready", 32'(tx_ready), 1);
        chk("abort_busy", 32'(tx_busy), 0);
        chk("abort_load", 32'(ple), 0);
        chk("abort_shift", 32'(se), 0);
        @(negedge clk);
        chk("abort_tx_next", 32'(tx), 1);
        arst = 1'b0;
        @(negedge clk);
        send_frame(8'h3C, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            hold = (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_frame(8'($urandom()), hold);
            if (!hold) @(negedge clk);
        end

        for (int i = 0; i < 3000; i++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom());
            @(negedge clk);
        end
        tx_valid = 1'b0;
        for (int i = 0; i < FB * CPB + 4 && !tx_ready; i++) @(negedge clk);
        chk("drain_ready", 32'(tx_ready), 1);
        chk("drain_tx", 32'(tx), 1);
        chk("no_overlap", 32'(overlap), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
